// File: rtl/multi_debouncer.sv
// N-channel button debouncer: per-channel synchroniser, WAIT/CHANGE debounce FSM,
// rise/fall event pulses and a once-per-press long-hold pulse, with a global freeze enable.
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 20,
    parameter int DEBOUNCE_TIME = 45000,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_W        = 24,
    parameter int HOLD_TIME     = 6000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] debounced_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_CHANGE = 2'b01
    } state_e;

    localparam logic [CNT_W-1:0]  DEB_LIMIT  = CNT_W'(DEBOUNCE_TIME);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_TIME);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TIME - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    logic [CHANNELS-1:0] deb_s;
    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] fall_s;
    logic [CHANNELS-1:0] hold_s;

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic                   sync_s;
            state_e                 state_q;
            state_e                 state_d;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   deb_q;
            logic                   deb_d;
            logic                   rise_q;
            logic                   rise_d;
            logic                   fall_q;
            logic                   fall_d;
            logic [HOLD_W-1:0]      hold_cnt_q;
            logic [HOLD_W-1:0]      hold_cnt_d;
            logic                   hold_q;
            logic                   hold_d;

            // Synchroniser shift chain; keeps running while the block is frozen.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], button_in[ch]};
            end

            assign sync_s = sync_q[SYNC_STAGES-1];

            // Debounce FSM: any return of sync to the current level aborts the count.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                deb_d   = deb_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (ena) begin
                    case (state_q)
                        ST_WAIT: begin
                            if (sync_s != deb_q) begin
                                state_d = ST_CHANGE;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                        ST_CHANGE: begin
                            if (sync_s == deb_q) begin
                                state_d = ST_WAIT;
                            end else if (cnt_q >= DEB_LIMIT) begin
                                state_d = ST_WAIT;
                                deb_d   = sync_s;
                                rise_d  = sync_s;
                                fall_d  = ~sync_s;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            state_d = ST_WAIT;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end

            // Hold counter saturates at HOLD_TIME so the pulse fires only once per press.
            always_comb begin
                hold_cnt_d = hold_cnt_q;
                hold_d     = 1'b0;
                if (!deb_q) begin
                    hold_cnt_d = '0;
                end else if (ena && (hold_cnt_q < HOLD_LIMIT)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    hold_d     = (hold_cnt_q == HOLD_LAST);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end

            // Per-channel state registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q     <= '0;
                    state_q    <= ST_WAIT;
                    cnt_q      <= '0;
                    deb_q      <= 1'b0;
                    rise_q     <= 1'b0;
                    fall_q     <= 1'b0;
                    hold_cnt_q <= '0;
                    hold_q     <= 1'b0;
                end else begin
                    sync_q     <= sync_d;
                    state_q    <= state_d;
                    cnt_q      <= cnt_d;
                    deb_q      <= deb_d;
                    rise_q     <= rise_d;
                    fall_q     <= fall_d;
                    hold_cnt_q <= hold_cnt_d;
                    hold_q     <= hold_d;
                end
            end

            assign deb_s[ch]  = deb_q;
            assign rise_s[ch] = rise_q;
            assign fall_s[ch] = fall_q;
            assign hold_s[ch] = hold_q;
        end
    endgenerate

    // A pulse landing in a frozen cycle is suppressed rather than delayed.
    assign debounced_out = deb_s;
    assign rise_pulse    = rise_s & {CHANNELS{ena}};
    assign fall_pulse    = fall_s & {CHANNELS{ena}};
    assign hold_pulse    = hold_s & {CHANNELS{ena}};

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: expected pulse events (cycle, channel, kind) are queued
// when stimulus is driven and matched against every pulse the DUT emits.
module tb_multi_debouncer;

    localparam int CH  = 4;
    localparam int DT  = 4;
    localparam int SS  = 2;
    localparam int HT  = 10;
    localparam int LAT = SS + DT + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [CH-1:0] button_in;
    logic [CH-1:0] debounced_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] hold_pulse;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    multi_debouncer #(
        .CHANNELS     (CH),
        .CNT_W        (8),
        .DEBOUNCE_TIME(DT),
        .SYNC_STAGES  (SS),
        .HOLD_W       (8),
        .HOLD_TIME    (HT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .button_in    (button_in),
        .debounced_out(debounced_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .hold_pulse   (hold_pulse)
    );

    always #5 clk = ~clk;

    // Count active edges; everything is sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int ev_code(input int c, input int ch, input int kind);
        return c * 64 + ch * 4 + kind;
    endfunction

    task automatic expect_ev(input int at, input int ch, input int kind);
        exp_q.push_back(ev_code(at, ch, kind));
    endtask

    function automatic logic pulse_bit(input int ch, input int kind);
        case (kind)
            0:       return rise_pulse[ch];
            1:       return fall_pulse[ch];
            default: return hold_pulse[ch];
        endcase
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pulse monitor: pops the scoreboard for every pulse seen (channel-major, rise/fall/hold order).
    always @(negedge clk) begin
        for (int ch = 0; ch < CH; ch++) begin
            for (int k = 0; k < 3; k++) begin
                if (pulse_bit(ch, k) === 1'b1) begin
                    if (exp_q.size() == 0)
                        check_eq("unexpected_pulse", ev_code(cyc, ch, k), 32'h0);
                    else
                        check_eq("pulse_event", ev_code(cyc, ch, k), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        rst_n     = 1'b0;
        ena       = 1'b1;
        button_in = 4'hF;
        repeat (3) @(negedge clk);
        check_eq("rst_deb",   32'(debounced_out), 32'h0);
        check_eq("rst_pulse", 32'({rise_pulse, fall_pulse, hold_pulse}), 32'h0);

        // 1: release reset with all buttons held
        rst_n = 1'b1;
        c = cyc;
        for (int ch = 0; ch < CH; ch++) expect_ev(c + LAT, ch, 0);
        for (int ch = 0; ch < CH; ch++) expect_ev(c + LAT + HT, ch, 2);
        wait_until(c + LAT - 1);
        check_eq("s1_deb_before", 32'(debounced_out), 32'h0);
        wait_until(c + LAT);
        check_eq("s1_deb_after", 32'(debounced_out), 32'hF);
        wait_until(c + 20);
        button_in = 4'h0;
        c = cyc;
        for (int ch = 0; ch < CH; ch++) expect_ev(c + LAT, ch, 1);
        wait_until(c + LAT + 4);
        check_eq("s1_deb_released", 32'(debounced_out), 32'h0);

        // 2: ch1 bounces every 3 clocks, then settles high
        c = cyc;
        for (int k = 0; k < 10; k++) begin
            wait_until(c + 3 * k);
            button_in[1] = (k % 2 == 0);
            check_eq("s2_bounce_deb", 32'(debounced_out), 32'h0);
        end
        wait_until(c + 30);
        button_in[1] = 1'b1;
        r = c + 30 + LAT;
        expect_ev(r, 1, 0);
        wait_until(r - 1);
        check_eq("s2_deb_before", 32'(debounced_out), 32'h0);
        wait_until(r);
        check_eq("s2_deb_after", 32'(debounced_out), 32'h2);
        button_in[1] = 1'b0;
        expect_ev(r + LAT, 1, 1);
        wait_until(r + LAT + 2);

        // 3: ch2 press then release right after the rise
        c = cyc;
        button_in[2] = 1'b1;
        expect_ev(c + LAT, 2, 0);
        wait_until(c + LAT);
        button_in[2] = 1'b0;
        r = cyc;
        expect_ev(r + LAT, 2, 1);
        wait_until(r + LAT - 1);
        check_eq("s3_deb_before", 32'(debounced_out), 32'h4);
        wait_until(r + LAT);
        check_eq("s3_deb_after", 32'(debounced_out), 32'h0);
        check_eq("s3_fall", 32'(fall_pulse), 32'h4);
        check_eq("s3_rise", 32'(rise_pulse), 32'h0);
        wait_until(r + LAT + 4);

        // 4: ch3 long hold, release, press again
        c = cyc;
        button_in[3] = 1'b1;
        expect_ev(c + LAT, 3, 0);
        expect_ev(c + LAT + HT, 3, 2);
        wait_until(c + 40);
        button_in[3] = 1'b0;
        expect_ev(c + 40 + LAT, 3, 1);
        wait_until(c + 50);
        button_in[3] = 1'b1;
        expect_ev(c + 50 + LAT, 3, 0);
        expect_ev(c + 50 + LAT + HT, 3, 2);
        wait_until(c + 75);
        button_in[3] = 1'b0;
        expect_ev(c + 75 + LAT, 3, 1);
        wait_until(c + 75 + LAT + 4);

        // 5: freeze for 5 clocks in the middle of ch0's CHANGE
        c = cyc;
        button_in[0] = 1'b1;
        expect_ev(c + LAT + 5, 0, 0);
        wait_until(c + 4);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("s5_frozen_pulses", 32'({rise_pulse, fall_pulse, hold_pulse}), 32'h0);
            @(negedge clk);
        end
        ena = 1'b1;
        wait_until(c + LAT + 4);
        check_eq("s5_deb_before", 32'(debounced_out), 32'h0);
        wait_until(c + LAT + 5);
        check_eq("s5_deb_after", 32'(debounced_out), 32'h1);
        button_in[0] = 1'b0;
        expect_ev(c + LAT + 5 + LAT, 0, 1);
        wait_until(c + 2 * LAT + 9);

        // 6: simultaneous rise, then async reset mid-CHANGE
        c = cyc;
        button_in = 4'hF;
        for (int ch = 0; ch < CH; ch++) expect_ev(c + LAT, ch, 0);
        wait_until(c + LAT);
        check_eq("s6_rise_all", 32'(rise_pulse), 32'hF);
        button_in = 4'h0;
        wait_until(c + LAT + 4);
        check_eq("s6_deb_pre_reset", 32'(debounced_out), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check_eq("s6_async_deb", 32'(debounced_out), 32'h0);
        check_eq("s6_async_pulse", 32'({rise_pulse, fall_pulse, hold_pulse}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 20);
        check_eq("s6_deb_final", 32'(debounced_out), 32'h0);
        check_eq("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
